// File: rtl/lab3_cache_pkg.sv
// Shared types for the lab3 cache memory subsystem: client ids and the 16B memory
// request/response messages exchanged between the caches and the test memory.
package lab3_cache_pkg;

  typedef logic client_id_t;

  localparam client_id_t CLIENT_ICACHE = 1'b0;
  localparam client_id_t CLIENT_DCACHE = 1'b1;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

// File: rtl/lab3_cache_ArbIdQueue.sv
// In-order FIFO of 1-bit client ids, one entry per outstanding memory request.
// A dequeue in the same cycle frees a slot, so enqueue is accepted even when full.
module lab3_cache_ArbIdQueue
  import lab3_cache_pkg::*;
#(
  parameter int p_depth = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enq_val,
  output logic       enq_rdy,
  input  client_id_t enq_msg,
  output logic       deq_val,
  input  logic       deq_rdy,
  output client_id_t deq_msg,
  output logic       full,
  output logic       empty
);

  localparam int PW = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int CW = $clog2(p_depth + 1);

  client_id_t    ids_q [p_depth];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq_fire, deq_fire;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(p_depth));
  assign deq_val  = !empty;
  assign deq_msg  = ids_q[head_q];
  assign deq_fire = deq_val && deq_rdy;
  assign enq_rdy  = !full || deq_fire;
  assign enq_fire = enq_val && enq_rdy;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_fire) tail_d = tail_q + PW'(1);
    if (deq_fire) head_d = head_q + PW'(1);
    if (enq_fire && !deq_fire)      count_d = count_q + CW'(1);
    else if (!enq_fire && deq_fire) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) ids_q[tail_q] <= enq_msg;
  end

endmodule

// File: rtl/lab3_cache_mem_port_arbiter.sv
// Round-robin sharing of one memory port between icache (0) and dcache (1); 0-cycle
// request and response paths, responses routed back in order via an id queue.
module lab3_cache_mem_port_arbiter
  import lab3_cache_pkg::*;
#(
  parameter int p_max_outstanding = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_val,
  output logic          req0_rdy,
  input  mem_req_16B_t  req0_msg,
  output logic          resp0_val,
  input  logic          resp0_rdy,
  output mem_resp_16B_t resp0_msg,
  input  logic          req1_val,
  output logic          req1_rdy,
  input  mem_req_16B_t  req1_msg,
  output logic          resp1_val,
  input  logic          resp1_rdy,
  output mem_resp_16B_t resp1_msg,
  output logic          mem_req_val,
  input  logic          mem_req_rdy,
  output mem_req_16B_t  mem_req_msg,
  input  logic          mem_resp_val,
  output logic          mem_resp_rdy,
  input  mem_resp_16B_t mem_resp_msg
);

  client_id_t grant, head_id, prio_q, prio_d;
  logic       granted_val, head_rdy;
  logic       q_enq_rdy, q_full, q_empty, q_full_eff;
  logic       mem_req_fire, mem_resp_fire;

  // Grant is recomputed every cycle; it is deliberately not locked across stalls.
  always_comb begin
    grant = CLIENT_ICACHE;
    if (req0_val && req1_val) grant = prio_q;
    else if (req1_val)        grant = CLIENT_DCACHE;
  end

  assign granted_val  = (grant == CLIENT_DCACHE) ? req1_val : req0_val;
  assign mem_req_msg  = (grant == CLIENT_DCACHE) ? req1_msg : req0_msg;
  assign mem_req_val  = granted_val && q_enq_rdy;
  assign mem_req_fire = mem_req_val && mem_req_rdy;

  assign q_full_eff = q_full && !mem_resp_fire;
  assign req0_rdy   = (grant == CLIENT_ICACHE) && mem_req_rdy && !q_full_eff;
  assign req1_rdy   = (grant == CLIENT_DCACHE) && mem_req_rdy && !q_full_eff;

  assign prio_d = mem_req_fire ? ~grant : prio_q;

  always_ff @(posedge clk) begin
    if (reset) prio_q <= CLIENT_ICACHE;
    else       prio_q <= prio_d;
  end

  // Routing follows the queue head only; the opaque field is never consulted.
  assign head_rdy      = (head_id == CLIENT_DCACHE) ? resp1_rdy : resp0_rdy;
  assign mem_resp_rdy  = !q_empty && head_rdy;
  assign mem_resp_fire = mem_resp_val && mem_resp_rdy;
  assign resp0_val     = mem_resp_val && !q_empty && (head_id == CLIENT_ICACHE);
  assign resp1_val     = mem_resp_val && !q_empty && (head_id == CLIENT_DCACHE);
  assign resp0_msg     = mem_resp_msg;
  assign resp1_msg     = mem_resp_msg;

  lab3_cache_ArbIdQueue #(.p_depth(p_max_outstanding)) u_idq (
    .clk     (clk),
    .reset   (reset),
    .enq_val (granted_val && mem_req_rdy),
    .enq_rdy (q_enq_rdy),
    .enq_msg (grant),
    .deq_val (),
    .deq_rdy (mem_resp_val && head_rdy),
    .deq_msg (head_id),
    .full    (q_full),
    .empty   (q_empty)
  );

endmodule

// File: tb/tb_lab3_cache_mem_port_arbiter.sv
// Directed and random bench for the cache memory port arbiter; a memory model and
// per-client scoreboards predict every response from the request that caused it.
module tb_lab3_cache_mem_port_arbiter;
  import lab3_cache_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req0_val, req0_rdy, resp0_val, resp0_rdy;
  logic          req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic          mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  mem_req_16B_t  req0_msg, req1_msg, mem_req_msg;
  mem_resp_16B_t resp0_msg, resp1_msg, mem_resp_msg;

  lab3_cache_mem_port_arbiter #(.p_max_outstanding(4)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg)
  );

  int checks = 0;
  int failures = 0;
  int unsigned seq0, seq1, left0, left1;
  int en0, en1, mrr_mode, mresp_mode, p0_mode, p1_mode;   // 0 off, 1 on, 2 random
  int n_rx0, n_rx1, nf;
  mem_resp_16B_t mem_q[$], exp0[$], exp1[$];
  logic grant_log[$], rlog[$];
  logic obs_f0, obs_f1, obs_mf, obs_mrf, obs_gid, obs_mrv;
  logic obs_r0rdy, obs_r1rdy, obs_p0v, obs_p1v, obs_mprdy;
  logic [7:0]  obs_p0opq;
  logic [31:0] obs_maddr;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic mem_req_16B_t mk_req(input logic c, input int unsigned s);
    mem_req_16B_t m;
    m.type_  = s[0] ? MEM_TYPE_WRITE : MEM_TYPE_READ;
    m.opaque = 8'(s + 5);
    m.addr   = 32'h1000 + 32'(s * 16) + (c ? 32'h8000_0000 : 32'h0);
    m.len    = 4'd0;
    m.data   = {(c ? 32'hDCDC_0000 : 32'h1C1C_0000), 32'(s), 32'(s * 3), 32'hFEED_0000 ^ 32'(s)};
    return m;
  endfunction

  // Test memory: echoes type/opaque/len, returns scrambled data for reads.
  function automatic mem_resp_16B_t mem_model(input mem_req_16B_t r);
    mem_resp_16B_t p;
    p.type_  = r.type_;
    p.opaque = r.opaque;
    p.test   = 2'b00;
    p.len    = r.len;
    p.data   = (r.type_ == MEM_TYPE_WRITE) ? 128'h0 : (r.data ^ {4{r.addr}});
    return p;
  endfunction

  function automatic logic pick(input int mode);
    return (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
  endfunction

  function automatic logic idle();
    return left0 == 0 && left1 == 0 && !req0_val && !req1_val && mem_q.size() == 0;
  endfunction

  // Valids are held until accepted; everything else follows its mode.
  task automatic apply();
    if (!(req0_val && !obs_f0)) req0_val = (left0 > 0) && pick(en0);
    if (!(req1_val && !obs_f1)) req1_val = (left1 > 0) && pick(en1);
    req0_msg = mk_req(1'b0, seq0);
    req1_msg = mk_req(1'b1, seq1);
    if (!(mem_resp_val && !obs_mrf && mresp_mode == 2))
      mem_resp_val = (mem_q.size() > 0) && pick(mresp_mode);
    mem_resp_msg = (mem_q.size() > 0) ? mem_q[0] : '0;
    mem_req_rdy  = pick(mrr_mode);
    resp0_rdy    = pick(p0_mode);
    resp1_rdy    = pick(p1_mode);
  endtask

  task automatic cyc();
    logic f0, f1, mf, rf0, rf1, mrf;
    @(negedge clk);
    f0  = req0_val && req0_rdy;
    f1  = req1_val && req1_rdy;
    mf  = mem_req_val && mem_req_rdy;
    rf0 = resp0_val && resp0_rdy;
    rf1 = resp1_val && resp1_rdy;
    mrf = mem_resp_val && mem_resp_rdy;
    if (f0 || f1 || mf) begin
      chk("req_fire_match", 192'(f0 || f1), 192'(mf));
      chk("req_single_grant", 192'(f0 && f1), 192'(0));
    end
    if (mf) begin
      chk("mem_req_msg", 192'(mem_req_msg), 192'(f1 ? req1_msg : req0_msg));
      mem_q.push_back(mem_model(mem_req_msg));
      grant_log.push_back(f1);
    end
    if (f0) begin exp0.push_back(mem_model(req0_msg)); left0--; seq0++; end
    if (f1) begin exp1.push_back(mem_model(req1_msg)); left1--; seq1++; end
    if (rf0 || rf1 || mrf) chk("resp_fire_match", 192'(rf0 || rf1), 192'(mrf));
    if (resp0_val || resp1_val) chk("resp_single_route", 192'(resp0_val && resp1_val), 192'(0));
    if (rf0) begin
      chk("resp0_expected", 192'(exp0.size() != 0), 192'(1));
      if (exp0.size() != 0) chk("resp0_msg", 192'(resp0_msg), 192'(exp0.pop_front()));
      n_rx0++;
      rlog.push_back(1'b0);
    end
    if (rf1) begin
      chk("resp1_expected", 192'(exp1.size() != 0), 192'(1));
      if (exp1.size() != 0) chk("resp1_msg", 192'(resp1_msg), 192'(exp1.pop_front()));
      n_rx1++;
      rlog.push_back(1'b1);
    end
    if (mrf && mem_q.size() > 0) void'(mem_q.pop_front());
    obs_f0 = f0; obs_f1 = f1; obs_mf = mf; obs_mrf = mrf; obs_gid = f1;
    obs_mrv = mem_req_val; obs_r0rdy = req0_rdy; obs_r1rdy = req1_rdy;
    obs_p0v = resp0_val; obs_p1v = resp1_val; obs_mprdy = mem_resp_rdy;
    obs_p0opq = resp0_msg.opaque; obs_maddr = mem_req_msg.addr;
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic clear_obs();
    obs_f0 = 0; obs_f1 = 0; obs_mf = 0; obs_mrf = 0; obs_gid = 0; obs_mrv = 0;
    obs_r0rdy = 0; obs_r1rdy = 0; obs_p0v = 0; obs_p1v = 0; obs_mprdy = 0;
    obs_p0opq = '0; obs_maddr = '0;
  endtask

  // Memory is reset alongside the arbiter, so in-flight responses vanish.
  task automatic do_reset();
    en0 = 0; en1 = 0; left0 = 0; left1 = 0; mresp_mode = 0;
    req0_val = 0; req1_val = 0; mem_resp_val = 0;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    mem_q.delete(); exp0.delete(); exp1.delete();
    clear_obs();
    apply();
  endtask

  task automatic drain(input string tag);
    mresp_mode = 1; p0_mode = 1; p1_mode = 1;
    apply();
    for (int i = 0; i < 60 && !idle(); i++) cyc();
    chk(tag, 192'(idle()), 192'(1));
  endtask

  initial begin
    reset = 1; seq0 = 0; seq1 = 0; left0 = 0; left1 = 0; n_rx0 = 0; n_rx1 = 0;
    en0 = 0; en1 = 0; mrr_mode = 0; mresp_mode = 0; p0_mode = 0; p1_mode = 0;
    req0_val = 0; req1_val = 0; resp0_rdy = 0; resp1_rdy = 0;
    mem_req_rdy = 0; mem_resp_val = 0;
    req0_msg = '0; req1_msg = '0; mem_resp_msg = '0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    reset = 0;

    // Reset state
    @(negedge clk);
    chk("rst_mem_req_val", 192'(mem_req_val), 192'(0));
    chk("rst_req0_rdy", 192'(req0_rdy), 192'(0));
    chk("rst_req1_rdy", 192'(req1_rdy), 192'(0));
    chk("rst_resp0_val", 192'(resp0_val), 192'(0));
    chk("rst_resp1_val", 192'(resp1_val), 192'(0));
    chk("rst_mem_resp_rdy", 192'(mem_resp_rdy), 192'(0));
    chk("rst_count", 192'(dut.u_idq.count_q), 192'(0));
    chk("rst_prio", 192'(dut.prio_q), 192'(0));

    // Stray response with nothing outstanding is held, never routed
    @(posedge clk);
    #1;
    mem_resp_val = 1; mem_req_rdy = 1; resp0_rdy = 1; resp1_rdy = 1;
    @(negedge clk);
    chk("empty_mem_resp_rdy", 192'(mem_resp_rdy), 192'(0));
    chk("empty_resp0_val", 192'(resp0_val), 192'(0));
    chk("empty_resp1_val", 192'(resp1_val), 192'(0));
    chk("idle_req0_rdy", 192'(req0_rdy), 192'(1));
    chk("idle_req1_rdy", 192'(req1_rdy), 192'(0));
    @(posedge clk);
    #1;
    mem_resp_val = 0;

    // 1: single icache read
    left0 = 1; en0 = 1; mrr_mode = 1;
    apply();
    cyc();
    chk("t1_fire", 192'(obs_mf), 192'(1));
    chk("t1_gid", 192'(obs_gid), 192'(0));
    chk("t1_addr", 192'(obs_maddr), 192'(32'h1000));
    mresp_mode = 1; p0_mode = 1; p1_mode = 1;
    apply();
    cyc();
    chk("t1_resp0_val", 192'(obs_p0v), 192'(1));
    chk("t1_resp1_val", 192'(obs_p1v), 192'(0));
    chk("t1_opaque", 192'(obs_p0opq), 192'(8'h05));

    // 2: both clients saturating, alternating grants from client 0
    do_reset();
    grant_log.delete(); rlog.delete();
    left0 = 4; left1 = 4; en0 = 1; en1 = 1; mrr_mode = 1; mresp_mode = 1;
    apply();
    for (int i = 0; i < 40 && !idle(); i++) cyc();
    chk("t2_done", 192'(idle()), 192'(1));
    chk("t2_ngrants", 192'(grant_log.size()), 192'(8));
    chk("t2_nresps", 192'(rlog.size()), 192'(8));
    for (int i = 0; i < grant_log.size(); i++) chk("t2_grant_order", 192'(grant_log[i]), 192'(i % 2));
    for (int i = 0; i < rlog.size(); i++) chk("t2_resp_order", 192'(rlog[i]), 192'(i % 2));

    // 3: fill the id queue, then bypass a full queue with a same-cycle response
    left0 = 3; left1 = 3; en0 = 1; en1 = 1; mresp_mode = 0;
    apply();
    nf = 0;
    repeat (4) begin cyc(); nf += int'(obs_mf); end
    chk("t3_accept4", 192'(nf), 192'(4));
    cyc();
    chk("t3_stall_req0_rdy", 192'(obs_r0rdy), 192'(0));
    chk("t3_stall_req1_rdy", 192'(obs_r1rdy), 192'(0));
    chk("t3_stall_mem_req_val", 192'(obs_mrv), 192'(0));
    chk("t3_count_full", 192'(dut.u_idq.count_q), 192'(4));
    mresp_mode = 1;
    apply();
    cyc();
    chk("t3_bypass_req_fire", 192'(obs_mf), 192'(1));
    chk("t3_bypass_resp_fire", 192'(obs_mrf), 192'(1));
    chk("t3_bypass_count", 192'(dut.u_idq.count_q), 192'(4));
    mresp_mode = 0;
    apply();
    cyc();
    chk("t3_stall_again", 192'(obs_mf), 192'(0));
    drain("t3_drain");

    // 4: head response blocked by dcache backpressure
    en0 = 0; en1 = 1; left1 = 1; mresp_mode = 0;
    apply();
    cyc();
    chk("t4_first_gid", 192'(obs_mf && obs_gid), 192'(1));
    en0 = 1; left0 = 1; en1 = 0;
    apply();
    cyc();
    chk("t4_second_gid", 192'(obs_mf && !obs_gid), 192'(1));
    en0 = 0; mresp_mode = 1; p0_mode = 1; p1_mode = 0;
    apply();
    repeat (3) begin
      cyc();
      chk("t4_mem_resp_rdy", 192'(obs_mprdy), 192'(0));
      chk("t4_resp0_val", 192'(obs_p0v), 192'(0));
      chk("t4_resp1_val", 192'(obs_p1v), 192'(1));
    end
    p1_mode = 1;
    apply();
    cyc();
    chk("t4_deliver", 192'(obs_p1v && obs_mrf), 192'(1));
    drain("t4_drain");

    // 5: reset with requests in flight
    en0 = 1; left0 = 3; mresp_mode = 0;
    apply();
    repeat (3) cyc();
    chk("t5_count_pre", 192'(dut.u_idq.count_q), 192'(3));
    chk("t5_prio_pre", 192'(dut.prio_q), 192'(1));
    do_reset();
    chk("t5_count_post", 192'(dut.u_idq.count_q), 192'(0));
    chk("t5_prio_post", 192'(dut.prio_q), 192'(0));
    en1 = 1; left1 = 1; mrr_mode = 1; p0_mode = 1; p1_mode = 1;
    apply();
    mem_resp_val = 1;
    cyc();
    chk("t5_resp0_val", 192'(obs_p0v), 192'(0));
    chk("t5_resp1_val", 192'(obs_p1v), 192'(0));
    chk("t5_new_req", 192'(obs_mf && obs_gid), 192'(1));
    drain("t5_drain");

    // 6: random handshakes on every interface
    n_rx0 = 0; n_rx1 = 0;
    left0 = 500; left1 = 500;
    en0 = 2; en1 = 2; mrr_mode = 2; mresp_mode = 2; p0_mode = 2; p1_mode = 2;
    apply();
    for (int i = 0; i < 20000 && !idle(); i++) cyc();
    chk("t6_done", 192'(idle()), 192'(1));
    chk("t6_rx0", 192'(n_rx0), 192'(500));
    chk("t6_rx1", 192'(n_rx1), 192'(500));
    chk("t6_exp0_empty", 192'(exp0.size()), 192'(0));
    chk("t6_exp1_empty", 192'(exp1.size()), 192'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
